// File: rtl/debug_overlay_renderer.sv
// Debug text overlay: a PC line plus a page of register lines shown as hex, composited
// over the game pixel stream. The values come from a frame-start snapshot. Latency is 2 cycles.
module debug_overlay_renderer #(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned ROWS_VISIBLE = 16,
  parameter int unsigned CELL_SHIFT   = 4,
  parameter logic [23:0] FG_RGB       = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB       = 24'h000000,
  localparam int unsigned NUM_PAGES   = (NUM_REGS + ROWS_VISIBLE - 1) / ROWS_VISIBLE,
  localparam int unsigned PW          = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1,
  localparam int unsigned IW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   debug_mode_in,
  input  logic                   freeze_in,
  input  logic                   page_next_in,
  input  logic [31:0]            pc_in,
  input  logic [NUM_REGS*32-1:0] reg_flat_in,
  input  logic [23:0]            game_rgb_in,
  output logic [7:0]             glyph_idx_out,
  input  logic [34:0]            glyph_map_in,
  output logic [23:0]            rgb_out,
  output logic [PW-1:0]          page_out
);

  logic [31:0]                r_pc;
  logic [NUM_REGS-1:0][31:0]  r_regs;
  logic [PW-1:0]              r_page;
  logic [34:0]                r_map;
  logic                       r_ovl;
  logic [23:0]                r_game;
  logic [CELL_SHIFT-1:0]      r_ox;
  logic [CELL_SHIFT-1:0]      r_oy;
  logic [23:0]                r_rgb;

  int unsigned w_col, w_row, w_idx, w_nsel;
  logic        w_in_ovl, w_valid, w_lit;
  logic [31:0] w_val;
  logic [3:0]  w_nib;
  logic [7:0]  w_hex, w_ch;
  int unsigned w_px, w_py;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_pc   <= '0;
      r_regs <= '0;
      r_page <= '0;
    end else begin
      if (hcount_in == '0 && vcount_in == '0 && !freeze_in) begin
        r_pc   <= pc_in;
        r_regs <= reg_flat_in;
      end
      if (page_next_in)
        r_page <= (32'(r_page) == NUM_PAGES - 1) ? '0 : r_page + 1'b1;
    end
  end

  // Stage 0: cell addressing and character selection
  always_comb begin
    w_col    = 32'(hcount_in) >> CELL_SHIFT;
    w_row    = 32'(vcount_in) >> CELL_SHIFT;
    w_in_ovl = debug_mode_in && (w_col < 16) && (w_row <= ROWS_VISIBLE);
    w_idx    = 32'(r_page) * ROWS_VISIBLE + w_row - 1;
    w_valid  = (w_row == 0) || (w_idx < NUM_REGS);
    w_val    = '0;
    if (w_row == 0)
      w_val = r_pc;
    else if (w_idx < NUM_REGS)
      w_val = r_regs[IW'(w_idx)];
    w_nsel = (w_col <= 10) ? 14 - w_col : 15 - w_col;
    w_nib  = 4'(w_val >> (4 * w_nsel));
    w_hex  = (w_nib < 4'd10) ? 8'h30 + 8'(w_nib) : 8'h37 + 8'(w_nib);
    case (w_col)
      0:       w_ch = (w_row == 0) ? "p" : "x";
      1:       w_ch = (w_row == 0) ? "c" : 8'h30 + 8'((w_idx / 10) % 10);
      2:       w_ch = (w_row == 0) ? " " : 8'h30 + 8'(w_idx % 10);
      3:       w_ch = ":";
      4:       w_ch = " ";
      5:       w_ch = "0";
      6:       w_ch = "x";
      11:      w_ch = "_";
      default: w_ch = w_hex;
    endcase
    glyph_idx_out = (rst_n_in && w_in_ovl && w_valid) ? w_ch : 8'h20;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_map  <= '0;
      r_ovl  <= 1'b0;
      r_game <= '0;
      r_ox   <= '0;
      r_oy   <= '0;
      r_rgb  <= '0;
    end else begin
      r_map  <= glyph_map_in;
      r_ovl  <= w_in_ovl;
      r_game <= game_rgb_in;
      r_ox   <= hcount_in[CELL_SHIFT-1:0];
      r_oy   <= vcount_in[CELL_SHIFT-1:0];
      r_rgb  <= !r_ovl ? r_game : (w_lit ? FG_RGB : BG_RGB);
    end
  end

  // Glyphs are 5x7 inside the cell; the cell offset is scaled down to an 8x8 grid
  always_comb begin
    w_px  = 32'(r_ox) >> (CELL_SHIFT - 3);
    w_py  = 32'(r_oy) >> (CELL_SHIFT - 3);
    w_lit = (w_px < 5) && (w_py < 7) && r_map[6'(w_py * 5 + w_px)];
  end

  assign rgb_out  = r_rgb;
  assign page_out = r_page;

endmodule
